alu_seq_driver: RTL and testbench

ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_fifo.sv | 56 +++++
 rtl/alu_seq_driver.sv | 117 +++++++++++
 tb/tb_alu_seq_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared widths, FSM encoding and packed command layout for the ALU sequence driver.
package alu_seq_pkg;
    localparam int DATA_W = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    localparam int CMD_W  = SEL_W + 3 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] expv;
    } cmd_t;
endpackage

// File: rtl/alu_seq_fifo.sv
// In-order command FIFO; power-of-two depth so pointers wrap naturally.
module alu_seq_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_seq_driver.sv
// Queues ALU test commands, drives an external ALU, captures and scores its result.
module alu_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_exp,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_c,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic              rsp_match,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  done_cnt,
    output logic              busy
);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic [DATA_W-1:0] exp_p1;
    logic [CMD_W-1:0]  push_data;
    logic [CMD_W-1:0]  head_data;
    cmd_t              head;
    logic              full;
    logic              empty;
    logic              pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign cmd_ready = !full;
    assign push_data = {cmd_sel, cmd_a, cmd_b, cmd_exp};
    assign head      = head_data;
    assign pop       = (state == ST_IDLE) && !empty;
    assign busy      = (state != ST_IDLE) || !empty;

    alu_seq_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head_data),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            exp_p1     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_c      <= '0;
            rsp_sel    <= '0;
            rsp_match  <= 1'b0;
            err_cnt    <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        alu_a      <= head.a;
                        alu_b      <= head.b;
                        alu_sel    <= head.sel;
                        exp_p1     <= head.expv;
                        settle_cnt <= '0;
                        state      <= ST_DRIVE;
                    end
                end
                // Operands have been stable for SETTLE cycles when the counter hits its last value.
                ST_DRIVE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        rsp_c     <= alu_c;
                        rsp_sel   <= alu_sel;
                        rsp_match <= (alu_c == exp_p1);
                        if (alu_c != exp_p1) begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= sat_inc(done_cnt);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver with an XOR stub ALU, SETTLE=1, DEPTH=4.
module tb_alu_seq_driver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_exp;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_c;
    logic [1:0] rsp_sel;
    logic       rsp_match;
    logic [7:0] err_cnt;
    logic [7:0] done_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    assign alu_c = alu_a ^ alu_b;

    alu_seq_driver #(
        .DEPTH  (4),
        .SETTLE (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_exp   (cmd_exp),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_sel   (rsp_sel),
        .rsp_match (rsp_match),
        .err_cnt   (err_cnt),
        .done_cnt  (done_cnt),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] sel, input logic [3:0] e);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_exp   = e;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_c"}, rsp_c, 0);
        check({tag, "_rsp_sel"}, rsp_sel, 0);
        check({tag, "_rsp_match"}, rsp_match, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_done_cnt"}, done_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int got;
        int vld_seen;
        logic accept;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        cmd_exp   = '0;
        rsp_ready = 1'b0;
        #1;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("por_rel_ready", cmd_ready, 1);

        // Single matching command: 1010 ^ 0101 = 1111.
        rsp_ready = 1'b1;
        set_cmd(4'b1010, 4'b0101, 2'b10, 4'b1111);
        tick();
        cmd_valid = 1'b0;
        check("one_e1_vld", rsp_valid, 0);
        tick();
        check("one_e2_vld", rsp_valid, 0);
        check("one_e2_alu_a", alu_a, 4'b1010);
        check("one_e2_alu_sel", alu_sel, 2'b10);
        check("one_e2_busy", busy, 1);
        tick();
        check("one_e3_vld", rsp_valid, 1);
        check("one_rsp_c", rsp_c, 4'b1111);
        check("one_rsp_sel", rsp_sel, 2'b10);
        check("one_match", rsp_match, 1);
        check("one_err", err_cnt, 0);
        tick();
        check("one_done", done_cnt, 1);
        check("one_vld_low", rsp_valid, 0);
        check("one_busy", busy, 0);
        check("one_alu_hold", alu_a, 4'b1010);

        // Asynchronous reset in the middle of a clock phase.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        check("midrst_rel_ready", cmd_ready, 1);

        // Mismatch: 0111 ^ 0101 = 0010, expected 0000.
        set_cmd(4'b0111, 4'b0101, 2'b00, 4'b0000);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mis_err_pre", err_cnt, 0);
        tick();
        check("mis_vld", rsp_valid, 1);
        check("mis_rsp_c", rsp_c, 4'b0010);
        check("mis_match", rsp_match, 0);
        check("mis_err", err_cnt, 1);
        tick();
        check("mis_done", done_cnt, 1);

        // Backpressure: six commands offered back to back, consumer stalled.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            set_cmd(4'(i), 4'b0000, 2'(i), 4'(i));
            check($sformatf("bp_ready_%0d", i), cmd_ready, (i <= 5) ? 1 : 0);
            if (i <= 5) tick();
        end
        repeat (3) tick();
        check("bp_stall_ready", cmd_ready, 0);
        check("bp_stall_vld", rsp_valid, 1);
        check("bp_stall_alu_a", alu_a, 1);
        check("bp_stall_rsp_c", rsp_c, 1);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (rsp_valid) begin
                check($sformatf("bp_order_%0d", got + 1), rsp_c, got + 1);
                got++;
            end
            accept = cmd_valid && cmd_ready;
            tick();
            if (accept) cmd_valid = 1'b0;
        end
        check("bp_rsp_count", got, 6);
        check("bp_sixth_taken", cmd_valid, 0);
        check("bp_done", done_cnt, 7);
        check("bp_err", err_cnt, 1);
        check("bp_busy", busy, 0);

        // Reset while DRIVE holds one command and two more are queued.
        rsp_ready = 1'b0;
        set_cmd(4'd3, 4'd1, 2'b01, 4'd2);
        tick();
        set_cmd(4'd4, 4'd1, 2'b01, 4'd5);
        tick();
        set_cmd(4'd5, 4'd1, 2'b01, 4'd4);
        tick();
        set_cmd(4'd6, 4'd1, 2'b01, 4'd7);
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("drst_alu_a", alu_a, 4);
        check("drst_busy_pre", busy, 1);
        check("drst_vld_pre", rsp_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("drst");
        tick();
        rst_n = 1'b1;
        vld_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid) vld_seen++;
        end
        check("drst_no_rsp", vld_seen, 0);
        check("drst_done", done_cnt, 0);
        check("drst_busy", busy, 0);
        check("drst_alu_a_post", alu_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
